// File: rtl/firebird7_in_gate1_tessent_tdr_data_ctl_w19.sv
// IJTAG TDR for the gate1 19-bit data-override mux: drives select/data to the mux and
// captures the mux data_out, flagging a mismatch against the active override.
module firebird7_in_gate1_tessent_tdr_data_ctl_w19 #(
  parameter int WIDTH = 19
) (
  input  logic             ijtag_tck,
  input  logic             ijtag_reset,
  input  logic             ijtag_sel,
  input  logic             ijtag_ce,
  input  logic             ijtag_se,
  input  logic             ijtag_ue,
  input  logic             ijtag_si,
  output logic             ijtag_so,
  input  logic [WIDTH-1:0] capture_data_in,
  output logic             ijtag_select,
  output logic [WIDTH-1:0] ijtag_data_out
);

  localparam int LEN = WIDTH + 2;

  logic [LEN-1:0]   sr_q, sr_d;
  logic             upd_sel_q, upd_sel_d;
  logic [WIDTH-1:0] upd_data_q, upd_data_d;
  logic             mismatch;

  // Capture beats shift when both enables are high; nothing moves while unselected.
  always_comb begin
    sr_d     = sr_q;
    mismatch = upd_sel_q & (capture_data_in != upd_data_q);
    if (ijtag_sel && ijtag_ce) begin
      sr_d = {mismatch, upd_sel_q, capture_data_in};
    end else if (ijtag_sel && ijtag_se) begin
      sr_d = {ijtag_si, sr_q[LEN-1:1]};
    end
  end

  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  // The mismatch flag (top chain bit) is observe-only and never reaches the update stage.
  always_comb begin
    upd_sel_d  = upd_sel_q;
    upd_data_d = upd_data_q;
    if (ijtag_sel && ijtag_ue) begin
      upd_sel_d  = sr_q[WIDTH];
      upd_data_d = sr_q[WIDTH-1:0];
    end
  end

  always_ff @(negedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      upd_sel_q  <= 1'b0;
      upd_data_q <= '0;
    end else begin
      upd_sel_q  <= upd_sel_d;
      upd_data_q <= upd_data_d;
    end
  end

  assign ijtag_so       = sr_q[0];
  assign ijtag_select   = upd_sel_q;
  assign ijtag_data_out = upd_data_q;

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_tdr_data_ctl_w19.sv
// Directed bench for the gate1 data-override TDR: scoreboard queue filled by the driver,
// drained and compared by an independent monitor process.
module tb_firebird7_in_gate1_tessent_tdr_data_ctl_w19;

  localparam int W = 21;

  logic        ijtag_tck = 1'b0;
  logic        ijtag_reset;
  logic        ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si;
  logic        ijtag_so;
  logic [18:0] capture_data_in;
  logic        ijtag_select;
  logic [18:0] ijtag_data_out;

  firebird7_in_gate1_tessent_tdr_data_ctl_w19 #(.WIDTH(19)) dut (
    .ijtag_tck       (ijtag_tck),
    .ijtag_reset     (ijtag_reset),
    .ijtag_sel       (ijtag_sel),
    .ijtag_ce        (ijtag_ce),
    .ijtag_se        (ijtag_se),
    .ijtag_ue        (ijtag_ue),
    .ijtag_si        (ijtag_si),
    .ijtag_so        (ijtag_so),
    .capture_data_in (capture_data_in),
    .ijtag_select    (ijtag_select),
    .ijtag_data_out  (ijtag_data_out)
  );

  // clock / reset
  always #5 ijtag_tck = ~ijtag_tck;

  // scoreboard: kind 0 = so, 1 = select, 2 = data
  logic [W-1:0] exp_q[$];
  int           kind_q[$];
  string        name_q[$];
  event         sample_ev;
  int           n_checks = 0;
  int           n_errors = 0;

  initial begin : monitor
    logic [W-1:0] e, act;
    int           k;
    string        n;
    forever begin
      @(sample_ev);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        k = kind_q.pop_front();
        n = name_q.pop_front();
        case (k)
          0:       act = {20'b0, ijtag_so};
          1:       act = {20'b0, ijtag_select};
          default: act = {2'b0, ijtag_data_out};
        endcase
        n_checks++;
        if (act !== e) begin
          n_errors++;
          $display("FAIL %s: got 0x%0h expected 0x%0h", n, act, e);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  // driver tasks
  task automatic expect_val(input int kind, input logic [W-1:0] v, input string name);
    exp_q.push_back(v);
    kind_q.push_back(kind);
    name_q.push_back(name);
    -> sample_ev;
  endtask

  task automatic check_outs(input logic sel_v, input logic [18:0] data_v, input string tag);
    expect_val(1, {20'b0, sel_v}, {tag, " select"});
    expect_val(2, {2'b0, data_v}, {tag, " data"});
  endtask

  // Drive one TCK cycle; returns just after the rising edge.
  task automatic cyc(input logic sel, input logic ce, input logic se, input logic ue,
                     input logic si);
    @(negedge ijtag_tck);
    #1;
    ijtag_sel = sel; ijtag_ce = ce; ijtag_se = se; ijtag_ue = ue; ijtag_si = si;
    @(posedge ijtag_tck);
    #1;
  endtask

  task automatic shift_word(input logic [W-1:0] word, input logic old_sel,
                            input logic [18:0] old_data, input string tag);
    for (int i = 0; i < W; i++) begin
      cyc(1'b1, 1'b0, 1'b1, 1'b0, word[i]);
      check_outs(old_sel, old_data, $sformatf("%s shift%0d", tag, i));
    end
  endtask

  task automatic do_update(input logic new_sel, input logic [18:0] new_data,
                           input logic old_sel, input logic [18:0] old_data,
                           input string tag);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check_outs(old_sel, old_data, {tag, " pre-update"});
    @(negedge ijtag_tck);
    #1;
    check_outs(new_sel, new_data, {tag, " post-update"});
    ijtag_ue = 1'b0;
  endtask

  task automatic capture(input logic [18:0] cdi);
    capture_data_in = cdi;
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic read_chain(input logic [W-1:0] word, input string tag);
    expect_val(0, {20'b0, word[0]}, {tag, " bit0"});
    for (int k = 1; k < W; k++) begin
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      expect_val(0, {20'b0, word[k]}, $sformatf("%s bit%0d", tag, k));
    end
  endtask

  initial begin : stimulus
    ijtag_reset = 1'b0;
    ijtag_sel = 0; ijtag_ce = 0; ijtag_se = 0; ijtag_ue = 0; ijtag_si = 0;
    capture_data_in = '0;
    #3;
    expect_val(0, 21'h0, "reset so");
    check_outs(1'b0, 19'h0, "reset");
    #9 ijtag_reset = 1'b1;

    // write override {0,1,0x5A5A5}
    shift_word(21'h0DA5A5, 1'b0, 19'h0, "write1");
    do_update(1'b1, 19'h5A5A5, 1'b0, 19'h0, "write1");

    // capture match
    capture(19'h5A5A5);
    read_chain(21'h0DA5A5, "cap_match");

    // capture mismatch with select active
    capture(19'h00001);
    read_chain(21'h180001, "cap_mis_sel1");

    // drop select, repeat mismatch capture
    shift_word(21'h05A5A5, 1'b1, 19'h5A5A5, "write2");
    do_update(1'b0, 19'h5A5A5, 1'b1, 19'h5A5A5, "write2");
    capture(19'h00001);
    read_chain(21'h000001, "cap_mis_sel0");

    // update-only write-back
    shift_word(21'h0DA5A5, 1'b0, 19'h5A5A5, "write3");
    do_update(1'b1, 19'h5A5A5, 1'b0, 19'h5A5A5, "write3");
    capture(19'h5A5A5);
    do_update(1'b1, 19'h5A5A5, 1'b1, 19'h5A5A5, "wrback");

    // unselected: everything must hold
    capture(19'h0F0F0);
    capture_data_in = 19'h7FFFF;
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    @(negedge ijtag_tck);
    #1;
    check_outs(1'b1, 19'h5A5A5, "unsel");
    read_chain(21'h18F0F0, "unsel");

    // ce and se together: capture wins
    capture_data_in = 19'h2AAAA;
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    read_chain(21'h1AAAAA, "prio");

    // reset mid-shift after loading all ones
    shift_word(21'h1FFFFF, 1'b1, 19'h5A5A5, "ones");
    do_update(1'b1, 19'h7FFFF, 1'b1, 19'h5A5A5, "ones");
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    expect_val(0, 21'h1, "pre-reset so");
    @(posedge ijtag_tck);
    #3 ijtag_reset = 1'b0;
    #1;
    expect_val(0, 21'h0, "midreset so");
    check_outs(1'b0, 19'h0, "midreset");
    ijtag_se = 1'b0; ijtag_si = 1'b0;
    @(negedge ijtag_tck);
    #2 ijtag_reset = 1'b1;
    #1;
    check_outs(1'b0, 19'h0, "post-release");
    capture(19'h33333);
    read_chain(21'h033333, "after_reset");

    #2;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
